// File: rtl/seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU encodings
// and the packed control word driven by the microcode.
package seq_pkg;

    localparam logic [3:0] OP_LDA  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_STA  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;

    // Number of ring-counter steps any instruction can reach (T1..T6)
    localparam int STEPS_USED = 6;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic mar_load;
        logic ram_out;
        logic ram_write;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic flags_load;
        logic out_load;
    } ctrl_word_t;

endpackage

// File: rtl/seq_microcode.sv
// Combinational microcode ROM: (step index, opcode) -> control word,
// ALU operation, last-step and illegal-opcode flags. Step 0 is T1.
module seq_microcode
    import seq_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [2:0]          step_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_word_t          ctrl_o,
    output logic [2:0]          alu_op_o,
    output logic                last_o,
    output logic                illegal_o
);

    logic       wide;
    logic [3:0] op;

    assign wide = |(opcode_i & ~OPCODE_W'(4'hF));
    assign op   = opcode_i[3:0];

    // Decode one microstep: shared fetch, then per-opcode execute
    always_comb begin
        ctrl_o    = '0;
        alu_op_o  = ALU_ADD;
        last_o    = 1'b0;
        illegal_o = 1'b0;
        if (step_i == 3'd0) begin
            ctrl_o.pc_out   = 1'b1;
            ctrl_o.mar_load = 1'b1;
        end else if (step_i == 3'd1) begin
            ctrl_o.pc_inc = 1'b1;
        end else if (step_i == 3'd2) begin
            ctrl_o.ram_out = 1'b1;
            ctrl_o.ir_load = 1'b1;
        end else if (wide) begin
            illegal_o = (step_i == 3'd3);
            last_o    = (step_i == 3'd3);
        end else begin
            case (op)
                OP_LDA: begin
                    if (step_i == 3'd3) begin
                        ctrl_o.ir_out   = 1'b1;
                        ctrl_o.mar_load = 1'b1;
                    end else if (step_i == 3'd4) begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.a_load  = 1'b1;
                        last_o         = 1'b1;
                    end
                end
                OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP: begin
                    alu_op_o = (op == OP_CMP) ? ALU_SUB : 3'(op - 4'd1);
                    if (step_i == 3'd3) begin
                        ctrl_o.ir_out   = 1'b1;
                        ctrl_o.mar_load = 1'b1;
                    end else if (step_i == 3'd4) begin
                        ctrl_o.ram_out = 1'b1;
                        ctrl_o.b_load  = 1'b1;
                    end else if (step_i == 3'd5) begin
                        ctrl_o.flags_load = 1'b1;
                        ctrl_o.alu_out    = (op != OP_CMP);
                        ctrl_o.a_load     = (op != OP_CMP);
                        last_o            = 1'b1;
                    end
                end
                OP_LDI: begin
                    if (step_i == 3'd3) begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.a_load = 1'b1;
                        last_o        = 1'b1;
                    end
                end
                OP_STA: begin
                    if (step_i == 3'd3) begin
                        ctrl_o.ir_out   = 1'b1;
                        ctrl_o.mar_load = 1'b1;
                    end else if (step_i == 3'd4) begin
                        ctrl_o.a_out     = 1'b1;
                        ctrl_o.ram_write = 1'b1;
                        last_o           = 1'b1;
                    end
                end
                OP_ADDI: begin
                    if (step_i == 3'd3) begin
                        ctrl_o.ir_out = 1'b1;
                        ctrl_o.b_load = 1'b1;
                    end else if (step_i == 3'd4) begin
                        ctrl_o.alu_out    = 1'b1;
                        ctrl_o.a_load     = 1'b1;
                        ctrl_o.flags_load = 1'b1;
                        last_o            = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (step_i == 3'd3) begin
                        ctrl_o.a_out    = 1'b1;
                        ctrl_o.out_load = 1'b1;
                        last_o          = 1'b1;
                    end
                end
                OP_HLT: begin
                    last_o = (step_i == 3'd3);
                end
                default: begin
                    illegal_o = (step_i == 3'd3);
                    last_o    = (step_i == 3'd3);
                end
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state ring counter with halt, stall and illegal-opcode handling.
// Optional SEQ_SINGLE_STEP_EN adds step_mode/step_req single stepping.
module control_sequencer
    import seq_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_req,
`endif
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                ctrl_pc_out,
    output logic                ctrl_pc_inc,
    output logic                ctrl_mar_load,
    output logic                ctrl_ram_out,
    output logic                ctrl_ram_write,
    output logic                ctrl_ir_load,
    output logic                ctrl_ir_out,
    output logic                ctrl_a_load,
    output logic                ctrl_a_out,
    output logic                ctrl_b_load,
    output logic                ctrl_alu_out,
    output logic                ctrl_flags_load,
    output logic                ctrl_out_load,
    output logic [2:0]          alu_op,
    output logic                instr_done,
    output logic                illegal,
    output logic                halted
);

    localparam logic [T_STATES-1:0] T1       = T_STATES'(1);
    localparam logic [T_STATES-1:0] LOW_MASK = T_STATES'(6'h3F);

    logic [T_STATES-1:0] t_q, t_d;
    logic                halted_q, halted_d;
    logic [2:0]          step_idx;
    logic                valid;
    logic                fire;
    logic                active;
    ctrl_word_t          mc_ctrl, ctrl;
    logic [2:0]          mc_alu;
    logic                mc_last, mc_illegal;

`ifdef SEQ_SINGLE_STEP_EN
    logic req_q, req_prev_q;

    // Register step_req and keep one cycle of history for edge detect
    always_ff @(posedge clk) begin
        if (clr) begin
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
        end else begin
            req_q      <= step_req;
            req_prev_q <= req_q;
        end
    end

    assign fire = ~step_mode | (req_q & ~req_prev_q);
`else
    assign fire = 1'b1;
`endif

    // Legal state: exactly one bit set, and within T1..T6
    assign valid = (t_q != '0)
                 && ((t_q & (t_q - T1)) == '0)
                 && ((t_q & ~LOW_MASK) == '0);

    // One-hot to step index for the microcode lookup
    always_comb begin
        step_idx = 3'd0;
        for (int i = 0; i < STEPS_USED; i++) begin
            if (t_q[i]) step_idx = 3'(i);
        end
    end

    seq_microcode #(.OPCODE_W(OPCODE_W)) u_mc (
        .step_i    (step_idx),
        .opcode_i  (ir_opcode),
        .ctrl_o    (mc_ctrl),
        .alu_op_o  (mc_alu),
        .last_o    (mc_last),
        .illegal_o (mc_illegal)
    );

    assign active = ~clr & en & ~halted_q & valid & fire;

    // State register: ring counter and sticky halt
    always_ff @(posedge clk) begin
        if (clr) begin
            t_q      <= T1;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    // Next state: advance, wrap at last step, halt, or recover to T1
    always_comb begin
        t_d      = t_q;
        halted_d = halted_q;
        if (halted_q) begin
            t_d = '0;
        end else if (!valid) begin
            t_d = T1;
        end else if (active) begin
            if (mc_last && ir_opcode == OPCODE_W'(OP_HLT)) begin
                t_d      = '0;
                halted_d = 1'b1;
            end else if (mc_last) begin
                t_d = T1;
            end else begin
                t_d = t_q << 1;
            end
        end
    end

    // Outputs: microcode gated by clear, stall, halt and single-step
    always_comb begin
        ctrl       = active ? mc_ctrl : '0;
        alu_op     = (clr | halted_q | ~valid) ? ALU_ADD : mc_alu;
        instr_done = active & mc_last;
        illegal    = active & mc_illegal;
    end

    assign t_state         = t_q;
    assign halted          = halted_q;
    assign ctrl_pc_out     = ctrl.pc_out;
    assign ctrl_pc_inc     = ctrl.pc_inc;
    assign ctrl_mar_load   = ctrl.mar_load;
    assign ctrl_ram_out    = ctrl.ram_out;
    assign ctrl_ram_write  = ctrl.ram_write;
    assign ctrl_ir_load    = ctrl.ir_load;
    assign ctrl_ir_out     = ctrl.ir_out;
    assign ctrl_a_load     = ctrl.a_load;
    assign ctrl_a_out      = ctrl.a_out;
    assign ctrl_b_load     = ctrl.b_load;
    assign ctrl_alu_out    = ctrl.alu_out;
    assign ctrl_flags_load = ctrl.flags_load;
    assign ctrl_out_load   = ctrl.out_load;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle outputs are
// queued as each instruction is driven and popped at every falling edge.
module tb_control_sequencer;

    localparam logic [12:0] PCO = 13'h1000;
    localparam logic [12:0] PCI = 13'h0800;
    localparam logic [12:0] MRL = 13'h0400;
    localparam logic [12:0] RMO = 13'h0200;
    localparam logic [12:0] RMW = 13'h0100;
    localparam logic [12:0] IRL = 13'h0080;
    localparam logic [12:0] IRO = 13'h0040;
    localparam logic [12:0] AL  = 13'h0020;
    localparam logic [12:0] AO  = 13'h0010;
    localparam logic [12:0] BL  = 13'h0008;
    localparam logic [12:0] ALO = 13'h0004;
    localparam logic [12:0] FL  = 13'h0002;
    localparam logic [12:0] OL  = 13'h0001;

    typedef struct {
        logic [5:0]  t;
        logic [12:0] c;
        logic [2:0]  alu;
        logic        done;
        logic        ill;
        logic        halt;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr, en;
    logic [3:0] ir_opcode;
    logic [5:0] t_state;
    logic       c_pco, c_pci, c_mrl, c_rmo, c_rmw, c_irl, c_iro;
    logic       c_al, c_ao, c_bl, c_alo, c_fl, c_ol;
    logic [2:0] alu_op;
    logic       instr_done, illegal, halted;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_mode, step_req;
`endif

    logic [12:0] ctrl_v;
    assign ctrl_v = {c_pco, c_pci, c_mrl, c_rmo, c_rmw, c_irl, c_iro,
                     c_al, c_ao, c_bl, c_alo, c_fl, c_ol};

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_W(4), .T_STATES(6)) dut (
        .clk             (clk),
        .clr             (clr),
        .en              (en),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode       (step_mode),
        .step_req        (step_req),
`endif
        .ir_opcode       (ir_opcode),
        .t_state         (t_state),
        .ctrl_pc_out     (c_pco),
        .ctrl_pc_inc     (c_pci),
        .ctrl_mar_load   (c_mrl),
        .ctrl_ram_out    (c_rmo),
        .ctrl_ram_write  (c_rmw),
        .ctrl_ir_load    (c_irl),
        .ctrl_ir_out     (c_iro),
        .ctrl_a_load     (c_al),
        .ctrl_a_out      (c_ao),
        .ctrl_b_load     (c_bl),
        .ctrl_alu_out    (c_alo),
        .ctrl_flags_load (c_fl),
        .ctrl_out_load   (c_ol),
        .alu_op          (alu_op),
        .instr_done      (instr_done),
        .illegal         (illegal),
        .halted          (halted)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int nsteps(input logic [3:0] op);
        case (op)
            4'h0, 4'h8, 4'hC:                     return 5;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:   return 6;
            default:                              return 4;
        endcase
    endfunction

    function automatic exp_t step_exp(input logic [3:0] op, input int k);
        exp_t e;
        e.t    = 6'b000001 << (k - 1);
        e.c    = '0;
        e.alu  = 3'd0;
        e.done = (k == nsteps(op));
        e.ill  = 1'b0;
        e.halt = 1'b0;
        if (k >= 4 && op >= 4'h1 && op <= 4'h6)
            e.alu = (op == 4'h6) ? 3'd1 : 3'(op - 4'd1);
        case (k)
            1: e.c = PCO | MRL;
            2: e.c = PCI;
            3: e.c = RMO | IRL;
            4: case (op)
                   4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8:
                       e.c = IRO | MRL;
                   4'h7:    e.c = IRO | AL;
                   4'hC:    e.c = IRO | BL;
                   4'hE:    e.c = AO | OL;
                   4'hF:    e.c = '0;
                   default: e.ill = 1'b1;
               endcase
            5: case (op)
                   4'h0:    e.c = RMO | AL;
                   4'h8:    e.c = AO | RMW;
                   4'hC:    e.c = ALO | AL | FL;
                   default: e.c = RMO | BL;
               endcase
            6: e.c = (op == 4'h6) ? FL : (ALO | AL | FL);
            default: e.c = '0;
        endcase
        return e;
    endfunction

    function automatic exp_t hold_exp(input logic [3:0] op, input int k);
        exp_t e;
        e      = step_exp(op, k);
        e.c    = '0;
        e.done = 1'b0;
        e.ill  = 1'b0;
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            check("t_state", 16'(t_state), 16'(e.t));
            check("ctrl", 16'(ctrl_v), 16'(e.c));
            check("alu_op", 16'(alu_op), 16'(e.alu));
            check("instr_done", 16'(instr_done), 16'(e.done));
            check("illegal", 16'(illegal), 16'(e.ill));
            check("halted", 16'(halted), 16'(e.halt));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] op, input int stall_at);
        ir_opcode = op;
        for (int k = 1; k <= nsteps(op); k++) begin
            if (k == stall_at) begin
                en = 1'b0;
                repeat (3) begin
                    sb.push_back(hold_exp(op, k));
                    cyc();
                end
                en = 1'b1;
            end
            sb.push_back(step_exp(op, k));
            cyc();
        end
    endtask

    initial begin
        exp_t e;
        clr       = 1'b1;
        en        = 1'b1;
        ir_opcode = 4'h0;
`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_req  = 1'b0;
`endif
        @(posedge clk);
        #1;
        e = hold_exp(4'h0, 1);
        sb.push_back(e);
        cyc();
        sb.push_back(e);
        cyc();
        clr = 1'b0;

        run(4'h0, 0);
        run(4'hE, 0);
        run(4'h1, 0);
        run(4'h2, 0);
        run(4'h6, 0);
        run(4'h3, 0);
        run(4'h4, 0);
        run(4'h5, 0);
        run(4'h7, 0);
        run(4'hC, 0);
        run(4'h8, 0);
        run(4'h9, 0);
        run(4'hA, 0);
        run(4'hD, 0);
        run(4'h1, 5);

        ir_opcode = 4'h8;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(step_exp(4'h8, k));
            cyc();
        end
        clr = 1'b1;
        sb.push_back(hold_exp(4'h8, 5));
        cyc();
        clr = 1'b0;
        run(4'h0, 0);

        run(4'hF, 0);
        e = hold_exp(4'h0, 1);
        e.t    = 6'b0;
        e.halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            en = (i % 3 != 1);
            sb.push_back(e);
            cyc();
        end
        en  = 1'b1;
        clr = 1'b1;
        sb.push_back(e);
        cyc();
        clr = 1'b0;
        run(4'h7, 0);

`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 1'b1;
        ir_opcode = 4'h0;
        for (int k = 1; k <= nsteps(4'h0); k++) begin
            step_req = 1'b0;
            sb.push_back(hold_exp(4'h0, k));
            cyc();
            step_req = 1'b1;
            sb.push_back(hold_exp(4'h0, k));
            cyc();
            sb.push_back(step_exp(4'h0, k));
            cyc();
        end
        step_req  = 1'b0;
        step_mode = 1'b0;
        run(4'hE, 0);
`endif

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
